// File: rtl/key_event_filter_pkg.sv
// key_event_filter shared types: event type codes and packed event record.
// Long-press support is enabled by defining KEY_EVT_LONG_PRESS_EN.
package Key_Evt_Pkg;

    localparam int KEY_EVT_IDX_WIDTH = 6;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'b01,
        EVT_RELEASE = 2'b10,
        EVT_LONG    = 2'b11
    } key_evt_type_e;

    typedef struct packed {
        key_evt_type_e                typ;
        logic [KEY_EVT_IDX_WIDTH-1:0] idx;
    } key_evt_t;

endpackage

// File: rtl/key_event_filter_if.sv
// key_event_filter event-FIFO port bundle.
// master = filter side, slave = interrupt/bus consumer side.
interface key_event_filter_if;

    logic       evt_valid;
    logic [7:0] evt_data;
    logic       evt_pop;
    logic       evt_overflow;
    logic       ovf_clr;
    logic       irq;

    modport master (
        output evt_valid,
        output evt_data,
        output evt_overflow,
        output irq,
        input  evt_pop,
        input  ovf_clr
    );

    modport slave (
        input  evt_valid,
        input  evt_data,
        input  evt_overflow,
        input  irq,
        output evt_pop,
        output ovf_clr
    );

endinterface

// File: rtl/key_event_filter_debounce.sv
// Per-key synchroniser, debounce counter, press FSM and pending event slot.
// KEY_EVT_LONG_PRESS_EN adds the long counter and LONG state.
module Key_Debounce_Cell
    import Key_Evt_Pkg::*;
#(
    parameter bit ACTIVE_LOW       = 1'b1,
    parameter int DEBOUNCE_SAMPLES = 8,
    parameter int LONG_SAMPLES     = 500
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick_i,
    input  logic          key_raw_i,
    input  logic          ack_i,
    output logic          stable_o,
    output logic          pending_o,
    output key_evt_type_e pending_type_o
);

    localparam int CW = $clog2(DEBOUNCE_SAMPLES);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_SAMPLES - 1);

    localparam logic [1:0] ST_RELEASED = 2'b00;
    localparam logic [1:0] ST_PRESSED  = 2'b01;
`ifdef KEY_EVT_LONG_PRESS_EN
    localparam logic [1:0] ST_LONG     = 2'b10;
    localparam int LW = $clog2(LONG_SAMPLES + 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_SAMPLES - 1);
    logic [LW-1:0] lcnt_q, lcnt_d;
`else
    if (LONG_SAMPLES < 1) begin : g_no_long
    end
`endif

    // Sync flops reset to the idle pad level so no false sample follows reset.
    localparam logic IDLE_LVL = ACTIVE_LOW;

    logic          sync1_q, sync2_q;
    logic          sample;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;
    logic          flip, rise, fall;
    logic [1:0]    state_q, state_d;
    logic          ev_set;
    key_evt_type_e ev_type;
    logic          pend_q, pend_d;
    key_evt_type_e ptype_q, ptype_d;

    assign sample = sync2_q ^ ACTIVE_LOW;
    assign flip   = tick_i && (sample != stable_q)
                  && (cnt_q == DEB_LAST);
    assign rise   = flip && !stable_q;
    assign fall   = flip && stable_q;

    // Two-flop synchroniser for the asynchronous pad.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= IDLE_LVL;
            sync2_q <= IDLE_LVL;
        end else begin
            sync1_q <= key_raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count consecutive differing samples, flip on the last one.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (tick_i) begin
            if (sample == stable_q) begin
                cnt_d = '0;
            end else if (flip) begin
                cnt_d    = '0;
                stable_d = !stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Press FSM; emits one event request per state change.
    always_comb begin
        state_d = state_q;
        ev_set  = 1'b0;
        ev_type = EVT_PRESS;
`ifdef KEY_EVT_LONG_PRESS_EN
        lcnt_d  = lcnt_q;
`endif
        unique case (state_q)
            ST_RELEASED: begin
                if (rise) begin
                    state_d = ST_PRESSED;
                    ev_set  = 1'b1;
                    ev_type = EVT_PRESS;
`ifdef KEY_EVT_LONG_PRESS_EN
                    lcnt_d  = '0;
`endif
                end
            end
            ST_PRESSED: begin
                if (fall) begin
                    state_d = ST_RELEASED;
                    ev_set  = 1'b1;
                    ev_type = EVT_RELEASE;
                end
`ifdef KEY_EVT_LONG_PRESS_EN
                else if (tick_i) begin
                    if (lcnt_q == LONG_LAST) begin
                        state_d = ST_LONG;
                        ev_set  = 1'b1;
                        ev_type = EVT_LONG;
                    end else begin
                        lcnt_d = lcnt_q + 1'b1;
                    end
                end
`endif
            end
`ifdef KEY_EVT_LONG_PRESS_EN
            ST_LONG: begin
                if (fall) begin
                    state_d = ST_RELEASED;
                    ev_set  = 1'b1;
                    ev_type = EVT_RELEASE;
                end
            end
`endif
            default: state_d = ST_RELEASED;
        endcase
    end

    // Pending slot: a new event overrides, the arbiter ack clears it.
    always_comb begin
        pend_d  = pend_q;
        ptype_d = ptype_q;
        if (ev_set) begin
            pend_d  = 1'b1;
            ptype_d = ev_type;
        end else if (ack_i) begin
            pend_d = 1'b0;
        end
    end

    // Debounce, FSM and pending-slot state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
            state_q  <= ST_RELEASED;
            pend_q   <= 1'b0;
            ptype_q  <= EVT_PRESS;
`ifdef KEY_EVT_LONG_PRESS_EN
            lcnt_q   <= '0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            state_q  <= state_d;
            pend_q   <= pend_d;
            ptype_q  <= ptype_d;
`ifdef KEY_EVT_LONG_PRESS_EN
            lcnt_q   <= lcnt_d;
`endif
        end
    end

    assign stable_o       = stable_q;
    assign pending_o      = pend_q;
    assign pending_type_o = ptype_q;

endmodule

// File: rtl/key_event_filter.sv
// Key/switch debouncer with press/release/long-press event FIFO and irq.
// Long-press events are built only when KEY_EVT_LONG_PRESS_EN is defined.
module key_event_filter
    import Key_Evt_Pkg::*;
#(
    parameter int KEY_NUM          = 4,
    parameter int ACTIVE_LOW       = 1,
    parameter int SAMPLE_DIV       = 1000,
    parameter int DEBOUNCE_SAMPLES = 8,
    parameter int LONG_SAMPLES     = 500,
    parameter int FIFO_DEPTH       = 8
) (
    input  logic               clk,
    input  logic               rst_sync,
    input  logic [KEY_NUM-1:0] key_raw,
    output logic [KEY_NUM-1:0] key_stable,
    key_event_filter_if.master evt
);

    localparam int PW = $clog2(SAMPLE_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(SAMPLE_DIV - 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [PW-1:0]  pre_q, pre_d;
    logic           tick;
    logic [KEY_NUM-1:0] pending, ack;
    key_evt_type_e  ptype [KEY_NUM];
    logic           push;
    key_evt_t       push_evt;
    logic [AW:0]    wr_q, rd_q, wr_d, rd_d;
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic           empty, full, do_push, do_pop, drop;
    logic           ovf_q, ovf_d;

    assign tick  = (pre_q == PRE_LAST);
    assign pre_d = tick ? '0 : pre_q + 1'b1;

    // Sample-tick prescaler.
    always_ff @(posedge clk or posedge rst_sync) begin
        if (rst_sync) pre_q <= '0;
        else          pre_q <= pre_d;
    end

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
        Key_Debounce_Cell #(
            .ACTIVE_LOW       (ACTIVE_LOW != 0),
            .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES),
            .LONG_SAMPLES     (LONG_SAMPLES)
        ) u_cell (
            .clk            (clk),
            .rst            (rst_sync),
            .tick_i         (tick),
            .key_raw_i      (key_raw[i]),
            .ack_i          (ack[i]),
            .stable_o       (key_stable[i]),
            .pending_o      (pending[i]),
            .pending_type_o (ptype[i])
        );
    end

    // Fixed-priority arbiter: lowest pending key index is pushed.
    always_comb begin
        ack      = '0;
        push     = 1'b0;
        push_evt = '0;
        for (int i = KEY_NUM - 1; i >= 0; i--) begin
            if (pending[i]) begin
                ack          = '0;
                ack[i]       = 1'b1;
                push         = 1'b1;
                push_evt.typ = ptype[i];
                push_evt.idx = KEY_EVT_IDX_WIDTH'(i);
            end
        end
    end

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW])
                  && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = evt.evt_pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    // Pointer and sticky-overflow next state.
    always_comb begin
        wr_d  = do_push ? wr_q + 1'b1 : wr_q;
        rd_d  = do_pop  ? rd_q + 1'b1 : rd_q;
        ovf_d = ovf_q;
        if (drop)             ovf_d = 1'b1;
        else if (evt.ovf_clr) ovf_d = 1'b0;
    end

    // FIFO pointers and overflow flag.
    always_ff @(posedge clk or posedge rst_sync) begin
        if (rst_sync) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            ovf_q <= ovf_d;
        end
    end

    // Event storage; contents only observed while non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_evt;
    end

    assign evt.evt_valid    = !empty;
    assign evt.irq          = !empty;
    assign evt.evt_data     = empty ? 8'h00 : mem_q[rd_q[AW-1:0]];
    assign evt.evt_overflow = ovf_q;

endmodule

// File: tb/tb_key_event_filter.sv
// Directed scoreboard bench for key_event_filter.
// Expected events are queued as keys are driven and checked on pop.
module tb_key_event_filter;

    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rst_sync;
    logic [3:0] key_raw;
    logic [3:0] key_stable;
    logic [7:0] exp_q [$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic       found;

    key_event_filter_if eif();

    key_event_filter #(
        .KEY_NUM          (4),
        .ACTIVE_LOW       (1),
        .SAMPLE_DIV       (SD),
        .DEBOUNCE_SAMPLES (4),
        .LONG_SAMPLES     (16),
        .FIFO_DEPTH       (4)
    ) dut (
        .clk        (clk),
        .rst_sync   (rst_sync),
        .key_raw    (key_raw),
        .key_stable (key_stable),
        .evt        (eif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic samples(input int n);
        repeat (n * SD) @(negedge clk);
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] exp;
        int waited;
        waited = 0;
        while (!eif.evt_valid && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        chk({tag, "_valid"}, eif.evt_valid, 1);
        chk(tag, eif.evt_data, exp);
        eif.evt_pop = 1'b1;
        @(negedge clk);
        eif.evt_pop = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_sync    = 1'b1;
        key_raw     = 4'hF;
        eif.evt_pop = 1'b0;
        eif.ovf_clr = 1'b0;
        cycles(3);
        chk("rst_stable", key_stable, 0);
        chk("rst_valid", eif.evt_valid, 0);
        chk("rst_data", eif.evt_data, 0);
        chk("rst_ovf", eif.evt_overflow, 0);
        chk("rst_irq", eif.irq, 0);
        rst_sync = 1'b0;
        cycles(5);

        // Clean press on key 1 with latency checks.
        key_raw[1] = 1'b0;
        exp_q.push_back(8'h41);
        cycles(14);
        chk("press_not_early", key_stable[1], 0);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            found = key_stable[1];
        end
        chk("press_flip", found, 1);
        chk("press_lat_e", eif.evt_valid, 0);
        @(negedge clk);
        chk("press_lat_e1", eif.evt_valid, 1);
        chk("press_irq", eif.irq, 1);
        samples(4);
        chk("press_irq_held", eif.irq, 1);
        pop_check("press_evt");
        chk("press_popped", eif.evt_valid, 0);
        chk("press_irq_clr", eif.irq, 0);
        key_raw[1] = 1'b1;
        exp_q.push_back(8'h81);
        samples(8);
        pop_check("press_rel");

        // Bounce on key 0 must be rejected.
        for (int k = 0; k < 6; k++) begin
            key_raw[0] = k[0];
            samples(1);
        end
        key_raw[0] = 1'b1;
        samples(10);
        chk("bounce_stable", key_stable[0], 0);
        chk("bounce_noevt", eif.evt_valid, 0);

        // Long press on key 1.
        key_raw[1] = 1'b0;
        exp_q.push_back(8'h41);
        samples(24);
        key_raw[1] = 1'b1;
`ifdef KEY_EVT_LONG_PRESS_EN
        exp_q.push_back(8'hC1);
`endif
        exp_q.push_back(8'h81);
        samples(10);
        pop_check("long_press");
`ifdef KEY_EVT_LONG_PRESS_EN
        pop_check("long_long");
`endif
        pop_check("long_rel");
        chk("long_no_second", eif.evt_valid, 0);
        chk("long_ovf", eif.evt_overflow, 0);

        // Keys 0 and 2 flip on the same tick.
        key_raw = 4'b1010;
        exp_q.push_back(8'h40);
        exp_q.push_back(8'h42);
        samples(8);
        pop_check("simul_k0");
        pop_check("simul_k2");
        key_raw = 4'hF;
        exp_q.push_back(8'h80);
        exp_q.push_back(8'h82);
        samples(8);
        pop_check("simul_r0");
        pop_check("simul_r2");
        chk("simul_empty", eif.evt_valid, 0);

        // Overflow: five events, four slots.
        key_raw = 4'b1010;
        exp_q.push_back(8'h40);
        exp_q.push_back(8'h42);
        samples(8);
        key_raw = 4'hF;
        exp_q.push_back(8'h80);
        exp_q.push_back(8'h82);
        samples(8);
        chk("ovf_before", eif.evt_overflow, 0);
        key_raw[3] = 1'b0;
        samples(8);
        chk("ovf_set", eif.evt_overflow, 1);
        chk("ovf_head", eif.evt_data, exp_q[0]);
        eif.ovf_clr = 1'b1;
        @(negedge clk);
        eif.ovf_clr = 1'b0;
        chk("ovf_clr", eif.evt_overflow, 0);

        // Release key 3 and pop in the same cycle the event is pushed.
        key_raw[3] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            found = !key_stable[3];
        end
        chk("full_rel_flip", found, 1);
        exp_q.push_back(8'h83);
        chk("full_head", eif.evt_data, exp_q.pop_front());
        eif.evt_pop = 1'b1;
        @(negedge clk);
        eif.evt_pop = 1'b0;
        chk("full_pushpop_ovf", eif.evt_overflow, 0);
        pop_check("full_e1");
        pop_check("full_e2");
        pop_check("full_e3");
        pop_check("full_e4");
        chk("full_count", eif.evt_valid, 0);

        // Reset while key 3 is held.
        key_raw[3] = 1'b0;
        exp_q.push_back(8'h43);
        samples(8);
        chk("prerst_stable", key_stable[3], 1);
        chk("prerst_valid", eif.evt_valid, 1);
        rst_sync = 1'b1;
        #1;
        chk("midrst_stable", key_stable, 0);
        chk("midrst_valid", eif.evt_valid, 0);
        chk("midrst_data", eif.evt_data, 0);
        chk("midrst_irq", eif.irq, 0);
        exp_q.delete();
        cycles(3);
        rst_sync = 1'b0;
        exp_q.push_back(8'h43);
        cycles(15);
        chk("rst_hold_early", key_stable[3], 0);
        cycles(1);
        chk("rst_hold_flip", key_stable[3], 1);
        chk("rst_hold_lat", eif.evt_valid, 0);
        pop_check("rst_hold_evt");
        key_raw = 4'hF;
        samples(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
